// File: rtl/ram_sp.sv
// Single-port synchronous RAM with registered read and a shared read/write address.
// Asynchronous reset clears every word and the output register to INIT_VALUE.
module ram_sp #(
   parameter int DATA_WIDTH   = 8,
   parameter int ADDR_WIDTH   = 5,
   parameter int INIT_VALUE   = 0,
   parameter int NEW_DATA_RDW = 1
) (
   input  logic                  clock,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] address,
   input  logic [DATA_WIDTH-1:0] data,
   input  logic                  wren,
   output logic [DATA_WIDTH-1:0] q
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;
   localparam logic [DATA_WIDTH-1:0] INIT_WORD = DATA_WIDTH'(INIT_VALUE);

   generate
      if (ADDR_WIDTH < 1) begin : g_bad_addr_width
         $error("ram_sp: ADDR_WIDTH must be at least 1");
      end
      if (DATA_WIDTH < 1) begin : g_bad_data_width
         $error("ram_sp: DATA_WIDTH must be at least 1");
      end
   endgenerate

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   // Storage: reset wipes the whole array so the key never holds stale data.
   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= INIT_WORD;
         end
      end else if (wren) begin
         mem[address] <= data;
      end
   end

   // Output register: q updates every edge; same-address write handling is chosen here.
   generate
      if (NEW_DATA_RDW != 0) begin : g_rdw_new
         always_ff @(posedge clock or posedge rst) begin
            if (rst) begin
               q <= INIT_WORD;
            end else if (wren) begin
               q <= data;
            end else begin
               q <= mem[address];
            end
         end
      end else begin : g_rdw_old
         always_ff @(posedge clock or posedge rst) begin
            if (rst) begin
               q <= INIT_WORD;
            end else begin
               q <= mem[address];
            end
         end
      end
   endgenerate

endmodule

// File: tb/tb_ram_sp.sv
// Scoreboard bench for ram_sp: both read-during-write modes run side by side on one stimulus.
module tb_ram_sp;

   logic       clock;
   logic       rst;
   logic [4:0] address;
   logic [7:0] data;
   logic       wren;
   logic [7:0] q_new;
   logic [7:0] q_old;

   int errors = 0;
   int checks = 0;

   logic [15:0] exp_q  [$];
   string       name_q [$];

   ram_sp #(.DATA_WIDTH(8), .ADDR_WIDTH(5), .INIT_VALUE(0), .NEW_DATA_RDW(1)) u_new (
      .clock   (clock),
      .rst     (rst),
      .address (address),
      .data    (data),
      .wren    (wren),
      .q       (q_new)
   );

   ram_sp #(.DATA_WIDTH(8), .ADDR_WIDTH(5), .INIT_VALUE(0), .NEW_DATA_RDW(0)) u_old (
      .clock   (clock),
      .rst     (rst),
      .address (address),
      .data    (data),
      .wren    (wren),
      .q       (q_old)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string nm, input string mode, input logic [7:0] act,
                        input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s (%s): got %02h expected %02h", nm, mode, act, exp);
      end
   endtask

   // Drive one cycle's inputs at the falling edge and queue what q must show after the next rise.
   task automatic drive(input logic [4:0] a, input logic [7:0] d, input logic w,
                        input logic [7:0] e_new, input logic [7:0] e_old, input string nm);
      @(negedge clock);
      address = a;
      data    = d;
      wren    = w;
      exp_q.push_back({e_new, e_old});
      name_q.push_back(nm);
   endtask

   always @(posedge clock) begin
      #1;
      if (exp_q.size() > 0) begin
         logic [15:0] e;
         string       nm;
         e  = exp_q.pop_front();
         nm = name_q.pop_front();
         check(nm, "new", q_new, e[15:8]);
         check(nm, "old", q_old, e[7:0]);
      end
   end

   initial begin
      logic [7:0] old_v;
      rst     = 1'b1;
      address = '0;
      data    = '0;
      wren    = 1'b0;
      #2;
      check("reset_q", "new", q_new, 8'h00);
      check("reset_q", "old", q_old, 8'h00);
      @(negedge clock);
      rst = 1'b0;

      for (int i = 0; i < 32; i++) drive(5'(i), 8'h00, 1'b0, 8'h00, 8'h00, "rst_read");

      drive(5'd0,  8'hA5, 1'b1, 8'hA5, 8'h00, "wr_a5");
      drive(5'd0,  8'h00, 1'b0, 8'hA5, 8'hA5, "rd_a5");
      drive(5'd31, 8'h3C, 1'b1, 8'h3C, 8'h00, "wr_3c");
      drive(5'd31, 8'h00, 1'b0, 8'h3C, 8'h3C, "rd_3c");
      drive(5'd0,  8'h00, 1'b0, 8'hA5, 8'hA5, "no_alias");

      drive(5'd0,  8'h11, 1'b1, 8'h11, 8'hA5, "wr_11");
      drive(5'd0,  8'h22, 1'b1, 8'h22, 8'h11, "rdw_22");
      drive(5'd0,  8'h00, 1'b0, 8'h22, 8'h22, "rd_22");

      // Address changes mid-cycle; q must stay put until the rising edge.
      drive(5'd31, 8'h00, 1'b0, 8'h3C, 8'h3C, "hold_next");
      #1;
      check("hold", "new", q_new, 8'h22);
      check("hold", "old", q_old, 8'h22);

      for (int i = 0; i < 32; i++) begin
         old_v = (i == 0) ? 8'h22 : ((i == 31) ? 8'h3C : 8'h00);
         drive(5'(i), 8'(i), 1'b1, 8'(i), old_v, "fill");
      end
      drive(5'd5,  8'h00, 1'b0, 8'h05, 8'h05, "fill_rd5");
      drive(5'd31, 8'h00, 1'b0, 8'h1F, 8'h1F, "fill_rd31");

      @(negedge clock);
      address = 5'd7;
      data    = 8'hFF;
      wren    = 1'b1;
      #2;
      rst = 1'b1;
      #1;
      check("midrst_q", "new", q_new, 8'h00);
      check("midrst_q", "old", q_old, 8'h00);
      @(posedge clock);
      #1;
      check("rst_hold_q", "new", q_new, 8'h00);
      check("rst_hold_q", "old", q_old, 8'h00);
      @(negedge clock);
      rst  = 1'b0;
      wren = 1'b0;
      data = 8'h00;

      for (int i = 0; i < 32; i++) drive(5'(i), 8'h00, 1'b0, 8'h00, 8'h00, "midrst_read");

      drive(5'd0, 8'h00, 1'b1, 8'h00, 8'h00, "key_full");
      drive(5'd0, 8'h5A, 1'b1, 8'h5A, 8'h00, "key_lim");
      drive(5'd0, 8'h00, 1'b0, 8'h5A, 8'h5A, "key_rd");

      for (int n = 0; n < 10 && exp_q.size() > 0; n++) @(posedge clock);
      #2;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: pending %0d expected 0", exp_q.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
